// File: rtl/serializer_pkg.sv
// serializer_pkg: shared sizing helpers and bit-order enum for the stream serializer family
package serializer_pkg;
  typedef enum logic {LSB_FIRST = 1'b0, MSB_FIRST = 1'b1} bit_order_e;
  function automatic int beats(input int data_width, input int lanes);
    return data_width / lanes;
  endfunction
  function automatic int cntr_bits(input int n_beats);
    return (n_beats > 1) ? $clog2(n_beats) : 1;
  endfunction
endpackage

// File: rtl/serializer_lane_mux.sv
// serializer_lane_mux: picks the current LANES-wide beat out of a word by beat index and bit order
module serializer_lane_mux
  import serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES = 1,
  parameter int CNTR_BITS = 3,
  parameter bit_order_e ORDER = LSB_FIRST
) (
  input  logic [DATA_WIDTH-1:0] shr_i,
  input  logic [CNTR_BITS-1:0]  cntr_i,
  output logic [LANES-1:0]      data_o
);
  localparam int BEATS = beats(DATA_WIDTH, LANES);
  localparam logic [CNTR_BITS-1:0] LAST = CNTR_BITS'(BEATS - 1);
  logic [CNTR_BITS-1:0] lane;
  // MSB-first walks the lanes from the top of the word downwards
  always_comb begin
    lane = (ORDER == MSB_FIRST) ? LAST - cntr_i : cntr_i;
    data_o = shr_i[lane * LANES +: LANES];
  end
endmodule

// File: rtl/serializer_stream.sv
// serializer_stream: valid/ready word-to-lane serializer with a one-word holding buffer; SERIALIZER_STREAM_PARITY_EN adds o_parity
module serializer_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [LANES-1:0]      o_data,
  output logic                  o_first,
  output logic                  o_last,
  output logic                  o_busy
`ifdef SERIALIZER_STREAM_PARITY_EN
  ,
  output logic                  o_parity
`endif
);
  import serializer_pkg::*;
  localparam int BEATS = beats(DATA_WIDTH, LANES);
  localparam int CW = cntr_bits(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  if (DATA_WIDTH < 2 || DATA_WIDTH % LANES != 0) begin : g_bad_cfg
    $error("serializer_stream: DATA_WIDTH must be >= 2 and a multiple of LANES");
  end
  logic [DATA_WIDTH-1:0] shr_q, shr_d, buf_q, buf_d;
  logic [CW-1:0] cntr_q, cntr_d;
  logic shr_full_q, shr_full_d, buf_full_q, buf_full_d;
  logic in_acc, beat_acc, done, load, to_buf;
  assign in_acc = i_valid & ~buf_full_q;
  assign beat_acc = shr_full_q & i_ready;
  assign done = beat_acc & (cntr_q == LAST);
  // The shifter refills from the buffer first; a new word goes to the buffer only while the shifter stays busy
  always_comb begin
    load = done ? (buf_full_q | in_acc) : (~shr_full_q & in_acc);
    to_buf = shr_full_q & ~done & in_acc;
    shr_d = load ? (buf_full_q ? buf_q : i_data) : shr_q;
    shr_full_d = load | (shr_full_q & ~done);
    cntr_d = (done | load) ? '0 : beat_acc ? cntr_q + CW'(1) : cntr_q;
    buf_d = to_buf ? i_data : buf_q;
    buf_full_d = to_buf | (buf_full_q & ~done);
  end
  // Control flags and beat counter are cleared asynchronously
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shr_full_q <= 1'b0;
      buf_full_q <= 1'b0;
      cntr_q <= '0;
    end else begin
      shr_full_q <= shr_full_d;
      buf_full_q <= buf_full_d;
      cntr_q <= cntr_d;
    end
  end
  // Word storage carries no reset; the flags say whether it is meaningful
  always_ff @(posedge i_clk) begin
    shr_q <= shr_d;
    buf_q <= buf_d;
  end
`ifdef SERIALIZER_STREAM_PARITY_EN
  logic par_q;
  // Parity is taken once when a word enters the shifter and held for all its beats
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) par_q <= 1'b0;
    else if (load) par_q <= ^shr_d;
  end
  assign o_parity = par_q;
`endif
  serializer_lane_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .LANES(LANES),
    .CNTR_BITS(CW),
    .ORDER(MSB_FIRST ? serializer_pkg::MSB_FIRST : serializer_pkg::LSB_FIRST)
  ) u_mux (
    .shr_i(shr_q),
    .cntr_i(cntr_q),
    .data_o(o_data)
  );
  assign o_valid = shr_full_q;
  assign o_ready = ~buf_full_q;
  assign o_first = shr_full_q & (cntr_q == '0);
  assign o_last = shr_full_q & (cntr_q == LAST);
  assign o_busy = shr_full_q | buf_full_q;
endmodule

// File: tb/tb_serializer_stream.sv
// tb_serializer_stream: random-stimulus scoreboard bench driving an LSB-first and an MSB-first instance in lockstep
module tb_serializer_stream;
  localparam int DW = 16, L = 2, NB = DW / L;
  typedef struct {
    logic [L-1:0] lsb, msb;
    bit first, last, par;
  } beat_t;
  beat_t q[$];
  logic clk = 1'b0, rst = 1'b1, i_valid = 1'b0, i_ready = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic o_ready_a, o_valid_a, o_first_a, o_last_a, o_busy_a;
  logic o_ready_b, o_valid_b, o_first_b, o_last_b, o_busy_b;
  logic [L-1:0] o_data_a, o_data_b;
  int checks = 0, failures = 0, words_in = 0, words_out = 0, ready_pct = 100, outst = 0;
  bit in_reset = 1'b1;
`ifdef SERIALIZER_STREAM_PARITY_EN
  logic o_parity_a, o_parity_b;
`endif

  serializer_stream #(.DATA_WIDTH(DW), .LANES(L), .MSB_FIRST(1'b0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready_a), .i_data(i_data),
    .o_valid(o_valid_a), .i_ready(i_ready), .o_data(o_data_a), .o_first(o_first_a),
    .o_last(o_last_a), .o_busy(o_busy_a)
`ifdef SERIALIZER_STREAM_PARITY_EN
    , .o_parity(o_parity_a)
`endif
  );
  serializer_stream #(.DATA_WIDTH(DW), .LANES(L), .MSB_FIRST(1'b1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready_b), .i_data(i_data),
    .o_valid(o_valid_b), .i_ready(i_ready), .o_data(o_data_b), .o_first(o_first_b),
    .o_last(o_last_b), .o_busy(o_busy_b)
`ifdef SERIALIZER_STREAM_PARITY_EN
    , .o_parity(o_parity_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_word(input logic [DW-1:0] w);
    for (int k = 0; k < NB; k++) begin
      beat_t b;
      b.lsb = L'(w >> (k * L));
      b.msb = L'(w >> (DW - (k + 1) * L));
      b.first = (k == 0);
      b.last = (k == NB - 1);
      b.par = ^w;
      q.push_back(b);
    end
    words_in++;
  endfunction

  task automatic send(input logic [DW-1:0] w);
    int t = 0;
    i_valid = 1'b1;
    i_data = w;
    @(negedge clk);
    while (!o_ready_a && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!o_ready_a) begin
      checks++;
      failures++;
      $display("FAIL send_timeout word=%h o_ready=0 required=1", w);
    end
    @(posedge clk);
    if (t < 500) push_word(w);
    #1 i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1 i_ready = ($urandom_range(99) < ready_pct);
  end

  always @(negedge clk) begin
    if (!in_reset) begin
      outst = words_in - words_out;
      chk("o_valid_a", o_valid_a, q.size() > 0);
      chk("o_valid_b", o_valid_b, q.size() > 0);
      chk("o_ready", o_ready_a, outst < 2);
      chk("o_ready_b", o_ready_b, outst < 2);
      chk("o_busy", o_busy_a, outst > 0);
      if (q.size() > 0 && o_valid_a) begin
        chk("o_data_lsb", o_data_a, q[0].lsb);
        chk("o_data_msb", o_data_b, q[0].msb);
        chk("o_first", o_first_a, q[0].first);
        chk("o_last", o_last_a, q[0].last);
        chk("o_first_b", o_first_b, q[0].first);
        chk("o_last_b", o_last_b, q[0].last);
`ifdef SERIALIZER_STREAM_PARITY_EN
        chk("o_parity", o_parity_a, q[0].par);
        chk("o_parity_b", o_parity_b, q[0].par);
`endif
        if (i_ready) begin
          if (q[0].last) words_out++;
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    #1;
    chk("rst_o_valid", o_valid_a, 0);
    chk("rst_o_ready", o_ready_a, 1);
    chk("rst_o_busy", o_busy_a, 0);
    chk("rst_o_first", o_first_a, 0);
    chk("rst_o_last", o_last_a, 0);
`ifdef SERIALIZER_STREAM_PARITY_EN
    chk("rst_o_parity", o_parity_a, 0);
`endif
    idle(3);
    rst = 1'b0;
    in_reset = 1'b0;
    idle(2);
    ready_pct = 100;
    send(16'h00A5);
    idle(10);
    send(16'h1234);
    send(16'hABCD);
    send(16'h0007);
    send(16'h0003);
    idle(20);
    ready_pct = 50;
    send(16'hF00F);
    for (int i = 0; i < 40; i++) begin
      send(16'($urandom));
      idle($urandom_range(0, 2) == 0 ? $urandom_range(1, 4) : 0);
    end
    ready_pct = 100;
    idle(40);
    send(16'h00FF);
    send(16'h1111);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    in_reset = 1'b1;
    #1;
    chk("async_rst_o_valid", o_valid_a, 0);
    chk("async_rst_o_valid_b", o_valid_b, 0);
    chk("async_rst_o_busy", o_busy_a, 0);
    chk("async_rst_o_ready", o_ready_a, 1);
`ifdef SERIALIZER_STREAM_PARITY_EN
    chk("async_rst_o_parity", o_parity_a, 0);
`endif
    q.delete();
    words_in = 0;
    words_out = 0;
    idle(3);
    rst = 1'b0;
    in_reset = 1'b0;
    idle(12);
    ready_pct = 70;
    for (int i = 0; i < 30; i++) begin
      send(16'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
    end
    ready_pct = 100;
    t = 0;
    while (q.size() > 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    idle(3);
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_o_busy", o_busy_a, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serializer_stream.md
Name: serializer_stream

Overview:
- Parametrised successor to the single-word serializer.
- Takes parallel words over a valid/ready handshake and emits them LANES bits per cycle over a valid/ready output stream.
- Bit order is selectable. A one-word holding buffer allows back-to-back words with zero idle cycles.
- Sits between parallel datapath producers and serial PHY/line-coding blocks (SPI/I2S/UART-style shifters).

Parameters:
- DATA_WIDTH, 8: input word width; must be ≥ 2.
- LANES, 1: output bits per beat; must divide DATA_WIDTH (elaboration-time assertion).
- MSB_FIRST, 0: 0 = LSB-first, 1 = MSB-first. Lane bit order inside a beat follows the same order.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  block can accept a word this cycle.
- i_data  input  DATA_WIDTH  parallel word.
- o_valid  output  1  output beat valid.
- i_ready  input  1  downstream accepts beat.
- o_data  output  LANES  current beat.
- o_first  output  1  beat 0 of a word (qualified by o_valid).
- o_last  output  1  beat BEATS-1 of a word (qualified by o_valid).
- o_busy  output  1  shifter or buffer holds data.

Behaviour:
- Derived constants: BEATS = DATA_WIDTH/LANES; CNTR_BITS = max(1, $clog2(BEATS)).
- Storage:
  - shifter register `shr`, beat counter `cntr` (0..BEATS-1), flag `shr_full`.
  - holding buffer `buf`, flag `buf_full`.
- Reset (async assert, sync deassert handled upstream): shr_full=0, buf_full=0, cntr=0, o_valid=0, o_ready=1, o_first=0, o_last=0, o_busy=0. Data registers are not reset.
- Handshakes:
  - Input accept = i_valid && o_ready.
  - Beat accept = o_valid && i_ready.
  - o_valid = shr_full.
  - o_ready = !buf_full (registered-flag based, no combinational path from i_ready).
  - o_data and i_data must not change while o_valid && !i_ready; the source must hold i_valid/i_data until accepted.
- Output mapping: o_data = lanes [cntr*LANES +: LANES] of shr for LSB-first; [DATA_WIDTH-(cntr+1)*LANES +: LANES] for MSB-first. Select by index; no physical shift needed.
- o_first = shr_full && cntr==0; o_last = shr_full && cntr==BEATS-1.
- `done` = beat accept && cntr==BEATS-1.
- Per-cycle update:
  - Beat accept && !done: cntr+1.
  - done: cntr→0. Then shr loads buf if buf_full (buf_full→0), else loads i_data if input accept, else shr_full→0.
  - !shr_full && input accept: shr←i_data, shr_full→1, cntr=0. Latency: first beat valid the cycle after accept.
  - shr_full && !done && input accept: buf←i_data, buf_full→1.
  - done && buf_full && input accept (o_ready was 1 only if buf empty, so cannot occur); done && !buf_full && input accept: word goes straight to shr.
  - Stall (!i_ready): counter, data and flags hold.
- Throughput: a continuous stream with i_ready=1 yields o_valid held high, with o_last followed immediately by o_first.
- o_busy = shr_full || buf_full.
- Reset mid-word: the partial word and buffered word are discarded; no further beats.

Optional Feature:
- SERIALIZER_STREAM_PARITY_EN defined: extra output port o_parity (1 bit) = XOR of all bits of the word currently in shr. It is computed at load and held for all beats of that word, and is 0 after reset.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package serializer_pkg: function beats(DATA_WIDTH, LANES), function cntr_bits(beats), enum bit_order_e {LSB_FIRST, MSB_FIRST}.
- One sub-module is natural: serializer_lane_mux (combinational beat selector from shr, cntr and bit order), reused by a future deserializer checker.

Test Plan:
- DATA_WIDTH=8, LANES=1, LSB-first; send 0xA5 with i_ready=1 -> o_data sequence 1,0,1,0,0,1,0,1; o_first on beat 0, o_last on beat 7; o_busy low the cycle after the last beat.
- Same configuration, MSB_FIRST=1, 0xA5 -> 1,0,1,0,0,1,0,1 reversed order, i.e. 1,0,1,0,0,1,0,1 read from bit 7 down to bit 0; check against 0x3C -> 0,0,1,1,1,1,0,0.
- DATA_WIDTH=16, LANES=4, LSB-first; words 0x1234 and 0xABCD back-to-back with i_ready=1 -> nibbles 4,3,2,1,D,C,B,A on 8 consecutive cycles with no o_valid gap; o_ready low while buf is full.
- Random i_ready stalls (50%) on 0xF00F, LANES=2 -> o_data stable during every stall; beats 3,3,0,0,0,0,3,3; exactly 8 beat accepts.
- Assert i_rst at beat 3 of 0xFF with a second word buffered -> o_valid=0, o_busy=0, o_ready=1 immediately (async); no residual beats after release.
- With SERIALIZER_STREAM_PARITY_EN: 0x07 -> o_parity=1 on all beats; 0x03 -> o_parity=0.
